// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared types and constants for the SAR ADC controller.
//   state_t    : controller FSM states
//   SETTLE_RST : settle register value after reset (9 -> 10 cycles = 1 us per bit at 10 MHz)
//   AVG_PASSES : conversion passes per start when SAR_ADC_AVG_EN is defined
//   ACC_W      : width of the averaging accumulator
package sar_adc_pkg;
   typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;
   localparam logic [7:0] SETTLE_RST = 8'd9;
   localparam int AVG_PASSES = 4;
   localparam int ACC_W = 10;
endpackage

// File: rtl/sar_adc_control_if.sv
// sar_adc_control_if: control/data bundle between a host and the SAR ADC controller.
//   start, load_settle, settle_data : host requests
//   comp_in                         : external comparator output (asynchronous)
//   dac_code, result, valid, busy   : controller outputs
//   master = host side, slave = controller side
interface sar_adc_control_if;
   logic       start;
   logic       comp_in;
   logic       load_settle;
   logic [7:0] settle_data;
   logic [7:0] dac_code;
   logic [7:0] result;
   logic       valid;
   logic       busy;
   modport master (output start, comp_in, load_settle, settle_data,
                   input dac_code, result, valid, busy);
   modport slave (input start, comp_in, load_settle, settle_data,
                  output dac_code, result, valid, busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   n_rst : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff (
   input  logic clk,
   input  logic n_rst,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
endmodule

// File: rtl/sar_adc_control.sv
// sar_adc_control: successive-approximation ADC controller (IDLE -> SAMPLE -> CONVERT -> DONE).
//   clk, n_rst  : clock and asynchronous active-low reset
//   VPWR, VGND  : power pins, no logic function
//   bus (slave) : start/load_settle/settle_data/comp_in in, dac_code/result/valid/busy out
//   SAMPLE_CYCLES (1..15): length of the sample phase with dac_code held at 0
//   Define SAR_ADC_AVG_EN to average four back-to-back conversions per start.
module sar_adc_control
   import sar_adc_pkg::*;
#(
   parameter int SAMPLE_CYCLES = 4
) (
   input  logic clk,
   input  logic n_rst,
   input  logic VPWR,
   input  logic VGND,
   sar_adc_control_if.slave bus
);
   state_t     state, state_n;
   logic       comp_s, vld, vld_n;
   logic [7:0] code, code_n, res, res_n, cnt, cnt_n, d_lat, d_n, settle, resolved;
   logic [2:0] idx, idx_n;
   logic [3:0] scnt, scnt_n;
   logic       unused_pwr;
`ifdef SAR_ADC_AVG_EN
   logic [1:0]       pass, pass_n;
   logic [ACC_W-1:0] acc, acc_n;
`endif
   assign unused_pwr = VPWR ^ VGND;
   sync_2ff u_sync (.clk(clk), .n_rst(n_rst), .d(bus.comp_in), .q(comp_s));
   always_comb begin
      state_n  = state;
      code_n   = code;
      res_n    = res;
      vld_n    = 1'b0;
      cnt_n    = cnt;
      d_n      = d_lat;
      idx_n    = idx;
      scnt_n   = scnt;
      // The trial bit is already set in code; drop it if Vin is below the DAC.
      resolved = comp_s ? code : code & ~(8'b1 << idx);
`ifdef SAR_ADC_AVG_EN
      pass_n   = pass;
      acc_n    = acc;
`endif
      case (state)
         IDLE: if (bus.start) begin
            state_n = SAMPLE;
            scnt_n  = 4'(SAMPLE_CYCLES - 1);
`ifdef SAR_ADC_AVG_EN
            pass_n  = 2'd0;
            acc_n   = '0;
`endif
         end
         SAMPLE: begin
            code_n = 8'h00;
            if (scnt != 4'd0) scnt_n = scnt - 4'd1;
            else begin
               state_n = CONVERT;
               idx_n   = 3'd7;
               code_n  = 8'h80;
`ifdef SAR_ADC_AVG_EN
               // A multi-pass run keeps the settle count captured by its first pass.
               d_n     = (pass == 2'd0) ? settle : d_lat;
`else
               d_n     = settle;
`endif
               cnt_n   = d_n;
            end
         end
         CONVERT: begin
            if (cnt != 8'd0) cnt_n = cnt - 8'd1;
            else if (idx != 3'd0) begin
               idx_n  = idx - 3'd1;
               code_n = resolved | (8'b1 << (idx - 3'd1));
               cnt_n  = d_lat;
            end else begin
`ifdef SAR_ADC_AVG_EN
               acc_n = acc + ACC_W'(resolved);
               if (pass == 2'(AVG_PASSES - 1)) begin
                  state_n = DONE;
                  res_n   = acc_n[ACC_W-1 -: 8];
                  vld_n   = 1'b1;
                  code_n  = resolved;
               end else begin
                  state_n = SAMPLE;
                  pass_n  = pass + 2'd1;
                  scnt_n  = 4'(SAMPLE_CYCLES - 1);
                  code_n  = 8'h00;
               end
`else
               state_n = DONE;
               res_n   = resolved;
               vld_n   = 1'b1;
               code_n  = resolved;
`endif
            end
         end
         DONE: begin
            state_n = IDLE;
            code_n  = 8'h00;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state  <= IDLE;
         code   <= 8'h00;
         res    <= 8'h00;
         vld    <= 1'b0;
         cnt    <= 8'h00;
         d_lat  <= SETTLE_RST;
         idx    <= 3'd7;
         scnt   <= 4'd0;
         settle <= SETTLE_RST;
`ifdef SAR_ADC_AVG_EN
         pass   <= 2'd0;
         acc    <= '0;
`endif
      end else begin
         state  <= state_n;
         code   <= code_n;
         res    <= res_n;
         vld    <= vld_n;
         cnt    <= cnt_n;
         d_lat  <= d_n;
         idx    <= idx_n;
         scnt   <= scnt_n;
         settle <= bus.load_settle ? bus.settle_data : settle;
`ifdef SAR_ADC_AVG_EN
         pass   <= pass_n;
         acc    <= acc_n;
`endif
      end
   assign bus.dac_code = code;
   assign bus.result   = res;
   assign bus.valid    = vld;
   assign bus.busy     = state != IDLE;
endmodule

// File: tb/tb_sar_adc_control.sv
// tb_sar_adc_control: directed self-checking bench for sar_adc_control.
// Comparator model: comp_in = (vin >= dac_code). Latency is the cycle number in which
// valid is seen, counting the cycle that follows the start-sampling edge as cycle 1.
module tb_sar_adc_control;
   localparam int S = 4;
   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [7:0] vin = 8'h00;
   int         compared = 0;
   int         mismatched = 0;
   int         vcnt = 0;
   sar_adc_control_if bus ();
   assign bus.comp_in = (vin >= bus.dac_code);
   sar_adc_control #(.SAMPLE_CYCLES(S)) dut (
      .clk(clk), .n_rst(n_rst), .VPWR(1'b1), .VGND(1'b0), .bus(bus)
   );
   always #50 clk = ~clk;
   always @(negedge clk) if (bus.valid === 1'b1) vcnt++;
   function automatic int exp_lat(input int d);
`ifdef SAR_ADC_AVG_EN
      return 4 * (S + 8 * (d + 1)) + 1;
`else
      return S + 8 * (d + 1) + 1;
`endif
   endfunction
   task automatic run_conv(input logic [7:0] v, input int disturb, input bit alt,
                           output int lat, output logic [7:0] res, output bit samp_nz);
      int cyc;
      vin = v;
      lat = -1;
      res = 8'hxx;
      samp_nz = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 1;
      while (cyc <= 2000) begin
         if (alt) vin = (((cyc - 1) / (S + 80)) % 2 == 1) ? 8'h41 : 8'h40;
         if (cyc <= S && bus.dac_code !== 8'h00) samp_nz = 1'b1;
         bus.start       = (cyc == disturb);
         bus.load_settle = (cyc == disturb);
         bus.settle_data = 8'd9;
         if (bus.valid === 1'b1) begin
            lat = cyc;
            res = bus.result;
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.start = 1'b0;
      bus.load_settle = 1'b0;
   endtask
   task automatic test_reset;
      bus.start = 1'b0;
      bus.load_settle = 1'b0;
      bus.settle_data = 8'h00;
      n_rst = 1'b0;
      #20;
      compared++; if (bus.dac_code !== 8'h00) begin mismatched++; $display("FAIL rst_dac: got %h want 00", bus.dac_code); end
      compared++; if (bus.result !== 8'h00) begin mismatched++; $display("FAIL rst_result: got %h want 00", bus.result); end
      compared++; if (bus.valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b want 0", bus.valid); end
      compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      @(negedge clk);
      n_rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      compared++; if (bus.busy !== 1'b0 || bus.dac_code !== 8'h00) begin mismatched++; $display("FAIL idle_after_rst: got busy=%b dac=%h want 0/00", bus.busy, bus.dac_code); end
   endtask
   task automatic test_basic;
      int lat, v0;
      logic [7:0] res;
      bit nz;
      v0 = vcnt;
      run_conv(8'hA5, 0, 1'b0, lat, res, nz);
      compared++; if (res !== 8'hA5) begin mismatched++; $display("FAIL basic_result: got %h want a5", res); end
      compared++; if (lat !== exp_lat(9)) begin mismatched++; $display("FAIL basic_latency: got %0d want %0d", lat, exp_lat(9)); end
      compared++; if (nz) begin mismatched++; $display("FAIL basic_sample_dac: got nonzero want 00"); end
      repeat (3) @(posedge clk);
      #1;
      compared++; if (vcnt - v0 !== 1) begin mismatched++; $display("FAIL basic_valid_count: got %0d want 1", vcnt - v0); end
      compared++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.result !== 8'hA5) begin mismatched++; $display("FAIL basic_after: got busy=%b valid=%b result=%h want 0/0/a5", bus.busy, bus.valid, bus.result); end
   endtask
   task automatic test_extremes;
      int lat;
      logic [7:0] res;
      bit nz;
      run_conv(8'h00, 0, 1'b0, lat, res, nz);
      compared++; if (res !== 8'h00) begin mismatched++; $display("FAIL zero_result: got %h want 00", res); end
      compared++; if (nz) begin mismatched++; $display("FAIL zero_sample_dac: got nonzero want 00"); end
      repeat (2) @(posedge clk);
      #1;
      run_conv(8'hFF, 0, 1'b0, lat, res, nz);
      compared++; if (res !== 8'hFF) begin mismatched++; $display("FAIL full_result: got %h want ff", res); end
      compared++; if (lat !== exp_lat(9)) begin mismatched++; $display("FAIL full_latency: got %0d want %0d", lat, exp_lat(9)); end
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic test_settle;
      int lat;
      logic [7:0] res;
      bit nz;
      @(negedge clk);
      bus.load_settle = 1'b1;
      bus.settle_data = 8'd2;
      @(negedge clk);
      bus.load_settle = 1'b0;
      run_conv(8'h3C, 0, 1'b0, lat, res, nz);
      compared++; if (res !== 8'h3C) begin mismatched++; $display("FAIL settle2_result: got %h want 3c", res); end
      compared++; if (lat !== exp_lat(2)) begin mismatched++; $display("FAIL settle2_latency: got %0d want %0d", lat, exp_lat(2)); end
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic test_back_to_back;
      int lat, v0;
      logic [7:0] res;
      bit nz;
      v0 = vcnt;
      run_conv(8'hC3, 10, 1'b0, lat, res, nz);
      compared++; if (res !== 8'hC3) begin mismatched++; $display("FAIL b2b_result: got %h want c3", res); end
      compared++; if (lat !== exp_lat(2)) begin mismatched++; $display("FAIL b2b_latency: got %0d want %0d", lat, exp_lat(2)); end
      repeat (120) @(posedge clk);
      #1;
      compared++; if (vcnt - v0 !== 1) begin mismatched++; $display("FAIL b2b_valid_count: got %0d want 1", vcnt - v0); end
      compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL b2b_no_second: got busy=%b want 0", bus.busy); end
      run_conv(8'h5A, 0, 1'b0, lat, res, nz);
      compared++; if (res !== 8'h5A) begin mismatched++; $display("FAIL newd_result: got %h want 5a", res); end
      compared++; if (lat !== exp_lat(9)) begin mismatched++; $display("FAIL newd_latency: got %0d want %0d", lat, exp_lat(9)); end
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic test_abort;
      int lat, v0;
      logic [7:0] res;
      bit nz;
      vin = 8'hFF;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (37) @(posedge clk);
      #1;
      v0 = vcnt;
      n_rst = 1'b0;
      #1;
      compared++; if (bus.dac_code !== 8'h00) begin mismatched++; $display("FAIL abort_dac: got %h want 00", bus.dac_code); end
      compared++; if (bus.result !== 8'h00) begin mismatched++; $display("FAIL abort_result: got %h want 00", bus.result); end
      compared++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL abort_flags: got valid=%b busy=%b want 0/0", bus.valid, bus.busy); end
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (150) @(posedge clk);
      #1;
      compared++; if (vcnt !== v0) begin mismatched++; $display("FAIL abort_no_valid: got %0d pulses want 0", vcnt - v0); end
      run_conv(8'h81, 0, 1'b0, lat, res, nz);
      compared++; if (res !== 8'h81) begin mismatched++; $display("FAIL restart_result: got %h want 81", res); end
      compared++; if (lat !== exp_lat(9)) begin mismatched++; $display("FAIL restart_latency: got %0d want %0d", lat, exp_lat(9)); end
      repeat (2) @(posedge clk);
      #1;
   endtask
`ifdef SAR_ADC_AVG_EN
   task automatic test_avg;
      int lat, v0;
      logic [7:0] res;
      bit nz;
      v0 = vcnt;
      run_conv(8'h40, 0, 1'b1, lat, res, nz);
      compared++; if (res !== 8'h40) begin mismatched++; $display("FAIL avg_result: got %h want 40", res); end
      compared++; if (lat !== 4 * (S + 80) + 1) begin mismatched++; $display("FAIL avg_latency: got %0d want %0d", lat, 4 * (S + 80) + 1); end
      repeat (3) @(posedge clk);
      #1;
      compared++; if (vcnt - v0 !== 1) begin mismatched++; $display("FAIL avg_valid_count: got %0d want 1", vcnt - v0); end
   endtask
`endif
   initial begin
      test_reset;
      test_basic;
      test_extremes;
      test_settle;
      test_back_to_back;
      test_abort;
`ifdef SAR_ADC_AVG_EN
      test_avg;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
